// File: rtl/idct8_stream_if.sv
// idct8_stream handshake bundle: coefficient input and sample output streams.
// slave is the transform side, master is the producer/consumer side.
interface idct8_stream_if #(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 8
);
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/idct8_stream.sv
// Streaming 8-point 1-D inverse DCT: 8 serial coefficients in, 8 samples out.
// Define IDCT_SAT_EN to clamp results; otherwise results wrap to OUT_WIDTH.
module idct8_stream #(
  parameter int IN_WIDTH   = 12,
  parameter int OUT_WIDTH  = 8,
  parameter int COEF_WIDTH = 12,
  parameter int FRAC       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  idct8_stream_if.slave io
);
  localparam int AW = IN_WIDTH + COEF_WIDTH + 3;
  localparam int PW = IN_WIDTH + COEF_WIDTH;

  // cos(j*pi/16) in Q16; rescaled to Q(FRAC-1) since a(k>0) = 1/2
  function automatic int cos16(int j);
    case (j)
      0:       return 65536;
      1:       return 64277;
      2:       return 60547;
      3:       return 54491;
      4:       return 46341;
      5:       return 36410;
      6:       return 25080;
      7:       return 12785;
      default: return 0;
    endcase
  endfunction

  // a(0) = sqrt(1/8) = cos(pi/4)/2, so row 0 uses the j = 4 magnitude
  function automatic int cval(int k, int n);
    int m, j, sh, r;
    bit neg;
    m = ((2 * n + 1) * k) % 32;
    if (k == 0) m = 4;
    if (m <= 8) begin
      j = m; neg = 1'b0;
    end else if (m <= 16) begin
      j = 16 - m; neg = 1'b1;
    end else if (m <= 24) begin
      j = m - 16; neg = 1'b1;
    end else begin
      j = 32 - m; neg = 1'b0;
    end
    sh = 17 - FRAC;
    r = (cos16(j) + (1 << (sh - 1))) >>> sh;
    return neg ? -r : r;
  endfunction

  logic signed [COEF_WIDTH-1:0] coef_tab [8][8];

  for (genvar gk = 0; gk < 8; gk++) begin : g_row
    for (genvar gn = 0; gn < 8; gn++) begin : g_col
      localparam logic signed [COEF_WIDTH-1:0] C =
        COEF_WIDTH'(cval(gk, gn));
      assign coef_tab[gk][gn] = C;
    end
  end

  typedef enum logic {EMPTY, DRAIN} state_t;

  state_t state_q, state_d;
  logic [2:0] k_q;
  logic [2:0] idx_q, idx_d;

  logic signed [AW-1:0]        acc_q [8];
  logic signed [PW-1:0]        prod  [8];
  logic signed [AW-1:0]        sum   [8];
  logic signed [AW-1:0]        rnd   [8];
  logic signed [OUT_WIDTH-1:0] res   [8];
  logic signed [OUT_WIDTH-1:0] obuf_q [8];

  logic fire_in, fire_out, last_in, rel_last;

`ifdef IDCT_SAT_EN
  localparam logic signed [AW-1:0] MAXV = AW'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [AW-1:0] MINV = AW'(-(2 ** (OUT_WIDTH - 1)));
`endif

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      prod[n] = io.in_data * coef_tab[k_q][n];
      sum[n]  = acc_q[n] + AW'(prod[n]);
      rnd[n]  = (sum[n] + AW'(1 << (FRAC - 1))) >>> FRAC;
`ifdef IDCT_SAT_EN
      if (rnd[n] > MAXV)
        res[n] = OUT_WIDTH'(MAXV);
      else if (rnd[n] < MINV)
        res[n] = OUT_WIDTH'(MINV);
      else
        res[n] = OUT_WIDTH'(rnd[n]);
`else
      res[n] = OUT_WIDTH'(rnd[n]);
`endif
    end
  end

  assign io.out_valid = (state_q == DRAIN);
  assign io.out_last  = io.out_valid & (idx_q == 3'd7);
  assign io.out_data  = io.out_valid ? obuf_q[idx_q] : '0;

  assign fire_out = io.out_valid & io.out_ready;
  assign rel_last = fire_out & io.out_last;

  // last beat may only land when the buffer is free or freeing this edge
  assign io.in_ready = (k_q != 3'd7) | (state_q == EMPTY) | rel_last;
  assign fire_in     = io.in_valid & io.in_ready;
  assign last_in     = fire_in & (k_q == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
      for (int n = 0; n < 8; n++) acc_q[n] <= '0;
    end else if (fire_in) begin
      k_q <= k_q + 3'd1;
      for (int n = 0; n < 8; n++)
        acc_q[n] <= last_in ? '0 : sum[n];
    end
  end

  always_ff @(posedge clk) begin
    if (last_in)
      for (int n = 0; n < 8; n++) obuf_q[n] <= res[n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      EMPTY: begin
        if (last_in) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (fire_out) begin
          if (idx_q == 3'd7) begin
            idx_d = '0;
            if (!last_in) state_d = EMPTY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = EMPTY;
        idx_d   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_idct8_stream.sv
// Directed bench for idct8_stream: DC, harmonic, saturation/wrap,
// backpressure, back-to-back and mid-block reset.
module tb_idct8_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  idct8_stream_if #(.IN_WIDTH(12), .OUT_WIDTH(8)) bus ();

  idct8_stream dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int q_data[$];
  int q_last[$];
  int q_cyc[$];

`ifdef IDCT_SAT_EN
  localparam int SAT_P = 127;
  localparam int SAT_N = -128;
`else
  localparam int SAT_P = -44;
  localparam int SAT_N = 44;
`endif

  int y_dc[8]   = '{64, 0, 0, 0, 0, 0, 0, 0};
  int y_ndc[8]  = '{-64, 0, 0, 0, 0, 0, 0, 0};
  int y_h1[8]   = '{0, 100, 0, 0, 0, 0, 0, 0};
  int y_sp[8]   = '{2047, 0, 0, 0, 0, 0, 0, 0};
  int y_sn[8]   = '{-2048, 0, 0, 0, 0, 0, 0, 0};
  int x_dc[8]   = '{23, 23, 23, 23, 23, 23, 23, 23};
  int x_ndc[8]  = '{-23, -23, -23, -23, -23, -23, -23, -23};
  int x_h1[8]   = '{49, 42, 28, 10, -10, -28, -42, -49};
  int x_sp[8]   = '{SAT_P, SAT_P, SAT_P, SAT_P, SAT_P, SAT_P, SAT_P, SAT_P};
  int x_sn[8]   = '{SAT_N, SAT_N, SAT_N, SAT_N, SAT_N, SAT_N, SAT_N, SAT_N};

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(negedge clk);
    #3;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      q_data.push_back(int'(bus.out_data));
      q_last.push_back(int'(bus.out_last));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(string tag, int obs, int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic send_beat(int y);
    bit acc;
    bit done;
    logic [31:0] v;
    done = 1'b0;
    v = y;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v[11:0];
    for (int t = 0; t < 200; t++) begin
      #1;
      acc = bus.in_ready;
      @(posedge clk);
      if (acc) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) chk("in_ready timeout", 0, 1);
  endtask

  task automatic send_block(int y[8]);
    for (int i = 0; i < 8; i++) send_beat(y[i]);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic check_block(string tag, int exp[8],
                             output int c0, output int c7);
    int t;
    c0 = 0;
    c7 = 0;
    for (int i = 0; i < 8; i++) begin
      t = 0;
      while (q_data.size() == 0 && t < 300) begin
        @(posedge clk);
        t++;
      end
      if (q_data.size() == 0) begin
        chk($sformatf("%s timeout", tag), 0, 1);
        return;
      end
      chk($sformatf("%s x%0d", tag, i), q_data.pop_front(), exp[i]);
      chk($sformatf("%s last%0d", tag, i), q_last.pop_front(),
          (i == 7) ? 1 : 0);
      if (i == 0) c0 = q_cyc.pop_front();
      else if (i == 7) c7 = q_cyc.pop_front();
      else void'(q_cyc.pop_front());
    end
    chk($sformatf("%s span", tag), c7 - c0, 7);
  endtask

  initial begin
    int a0, a7, b0, b7, c0, c7;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst in_ready", int'(bus.in_ready), 1);
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst out_last", int'(bus.out_last), 0);
    chk("rst out_data", int'(bus.out_data), 0);

    // DC block and first-sample latency
    bus.out_ready = 1'b1;
    send_block(y_dc);
    @(negedge clk);
    #1;
    chk("dc latency", int'(bus.out_valid), 1);
    bus.in_valid = 1'b0;
    check_block("dc", x_dc, a0, a7);

    send_block(y_h1);
    idle();
    check_block("h1", x_h1, a0, a7);

    send_block(y_sp);
    idle();
    check_block("satp", x_sp, a0, a7);

    send_block(y_sn);
    idle();
    check_block("satn", x_sn, a0, a7);

    // Backpressure: A stalls, B parks at k = 7
    @(negedge clk);
    bus.out_ready = 1'b0;
    send_block(y_h1);
    for (int i = 0; i < 7; i++) send_beat(y_dc[i]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = '0;
      #1;
      chk($sformatf("bp in_ready%0d", i), int'(bus.in_ready), 0);
      chk($sformatf("bp hold%0d", i), int'(bus.out_data), 49);
      chk($sformatf("bp valid%0d", i), int'(bus.out_valid), 1);
    end
    fork
      begin
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join_none
    send_beat(y_dc[7]);
    idle();
    check_block("bp A", x_h1, a0, a7);
    check_block("bp B", x_dc, b0, b7);
    chk("bp gap", b0 - a7, 1);

    // Back-to-back streaming
    send_block(y_dc);
    send_block(y_h1);
    send_block(y_ndc);
    idle();
    check_block("b2b0", x_dc, a0, a7);
    check_block("b2b1", x_h1, b0, b7);
    check_block("b2b2", x_ndc, c0, c7);
    chk("b2b gap1", b0 - a7, 1);
    chk("b2b gap2", c0 - b7, 1);

    // Reset mid-block discards the partial sums
    for (int i = 0; i < 5; i++) send_beat(y_h1[i] + 30);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid rst in_ready", int'(bus.in_ready), 1);
    chk("mid rst out_valid", int'(bus.out_valid), 0);
    chk("mid rst queue", q_data.size(), 0);
    send_block(y_dc);
    idle();
    check_block("after rst", x_dc, a0, a7);

    repeat (4) @(negedge clk);
    chk("tail queue", q_data.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1);
  end
endmodule
